ifetch_mem_resp: RTL
====================

Name: ifetch_mem_resp

Overview:
- Instruction-side memory responder: the responder end of the fetch request handshake (read request / address accepted / read data valid) driven by the PC stage.
- Accepts one fetch address per cycle and looks it up in an internal word-addressed instruction RAM.
- Returns 32-bit instruction words in request order after a fixed pipeline latency, through a response FIFO with downstream backpressure.
- Provides a backdoor load port for program image preload and a flush input to discard outstanding fetches on redirect.

Parameters:
- LATENCY, 2, cycles from request acceptance to FIFO entry (>=1).
- DEPTH, 4, max outstanding requests (in pipe + in FIFO); power of two.
- MEM_WORDS, 4096, 32-bit words in internal RAM; power of two.
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- read_req_i  in  1  fetch request valid
- addr_i  in  64  fetch byte address
- addr_ok_o  out  1  request accepted this cycle when read_req_i also high
- flush_i  in  1  discard all outstanding requests and responses
- rdata_valid_o  out  1  response valid
- rdata_o  out  32  instruction word
- rdata_addr_o  out  64  address of returned word
- rdata_ready_i  in  1  consumer takes response
- load_wen_i  in  1  backdoor write enable
- load_addr_i  in  64  backdoor byte address
- load_data_i  in  32  backdoor data
- err_o  out  1  access error; present only with IFETCH_ACCESS_ERR_EN

Behaviour:
- Reset (async, rst high): pipe valids=0, FIFO empty, credit count=0. Outputs: addr_ok_o=0, rdata_valid_o=0, rdata_o=0, rdata_addr_o=0, err_o=0. RAM contents are not reset.
- Credit count: number of requests held in the pipe plus the FIFO, range 0..DEPTH.
- addr_ok_o = ~rst & ~flush_i & (count < DEPTH). This is combinational and must not depend on read_req_i.
- Accept = read_req_i & addr_ok_o:
  - RAM is read at index ((addr_i - BASE_ADDR) >> 2) mod MEM_WORDS.
  - addr_i[1:0] is ignored.
  - {data, addr} enters pipe stage 1.
- Pipe: LATENCY register stages with a valid bit per stage, always advancing with no stall. The stage-LATENCY output is pushed into the FIFO; credit accounting guarantees the FIFO never overflows.
- A word accepted in cycle N is visible on rdata_valid_o at the clock edge ending cycle N+LATENCY, provided the FIFO was empty (LATENCY cycles latency).
- Output: rdata_valid_o = FIFO non-empty & ~flush_i. rdata_o and rdata_addr_o show the FIFO head and hold stable while rdata_valid_o & ~rdata_ready_i.
- Pop = rdata_valid_o & rdata_ready_i.
- Count update:
  - +1 on accept, -1 on pop.
  - Accept and pop in the same cycle: unchanged.
  - A push into the FIFO from the pipe does not change count.
- FIFO full with count==DEPTH: addr_ok_o=0. A pop in the same cycle does not raise addr_ok_o until the next cycle (no combinational ready-to-ok path).
- Simultaneous FIFO push from the pipe and pop: both occur; ordering is preserved.
- Flush (flush_i high for one or more cycles):
  - In that cycle no accept and no pop.
  - At the clock edge, all pipe valids clear, FIFO empties, count=0.
  - A request presented in the flush cycle is not accepted and must be re-presented.
- Backdoor write: on load_wen_i, RAM[((load_addr_i - BASE_ADDR) >> 2) mod MEM_WORDS] = load_data_i at the edge.
  - A same-cycle accept to the same word returns the old data (read-before-write).
  - Writes are independent of flush and of the credit count.
- Throughput: one accept per cycle sustained while rdata_ready_i is held high; DEPTH >= LATENCY+1 is required for no bubbles.

Optional Feature:
- Macro: IFETCH_ACCESS_ERR_EN.
- Enabled:
  - Each response carries an err bit, set when addr_i[1:0] != 0 or when (addr_i - BASE_ADDR) >= 4*MEM_WORDS (unsigned, so addresses below BASE_ADDR also flag).
  - On error: rdata_o=0 and err_o=1 with that response. The RAM is not read.
  - err_o is 0 whenever rdata_valid_o is 0.
- Disabled: the err_o port and err logic are absent; out-of-range addresses wrap modulo MEM_WORDS and the low 2 bits are ignored.

Test Plan:
1. Preload RAM[0]=32'h0000_0413, RAM[1]=32'h0010_0493 via backdoor. Then request 0x8000_0000 and 0x8000_0004 on consecutive cycles with ready held high. Required: valid for two consecutive cycles starting exactly 2 cycles after the first accept, returning 0x00000413 then 0x00100493, with rdata_addr_o matching.
2. ready=0, issue 6 back-to-back requests. Required: addr_ok_o drops after the 4th accept and the FIFO holds 4 entries. When ready rises, 4 in-order responses; addr_ok_o reasserts the cycle after the first pop.
3. Issue 3 requests, assert flush_i on the cycle after the third accept, with a request also presented in that cycle. Required: no response is ever returned for those 4, and count=0 after the flush. A new request to 0x8000_0008 returns RAM[2] after 2 cycles.
4. Backdoor-write 0xDEADBEEF to 0x8000_0010 in the same cycle as a fetch of 0x8000_0010 (old value 0x13). Required: response=0x00000013; a subsequent fetch returns 0xDEADBEEF.
5. Assert rst mid-stream with 2 responses pending. Required: outputs go to 0 immediately (asynchronous) and no stale response appears after rst is released.
6. (IFETCH_ACCESS_ERR_EN) Fetch 0x8000_0002 and 0x7FFF_FFFC. Required: both responses have err_o=1 and rdata_o=0. Without the macro, 0x8000_0002 returns RAM[0].

Source files
------------

// File: rtl/ifetch_mem_resp.sv
// Instruction-side fetch responder: word RAM lookup, fixed-latency pipe, credit-managed response FIFO.
// Optional access-error reporting (err_o) is built when IFETCH_ACCESS_ERR_EN is defined.
module ifetch_mem_resp #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req_i,
    input  logic [63:0] addr_i,
    output logic        addr_ok_o,
    input  logic        flush_i,
    output logic        rdata_valid_o,
    output logic [31:0] rdata_o,
    output logic [63:0] rdata_addr_o,
    input  logic        rdata_ready_i,
    input  logic        load_wen_i,
    input  logic [63:0] load_addr_i,
    input  logic [31:0] load_data_i
`ifdef IFETCH_ACCESS_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic [31:0] data;
        logic [63:0] addr;
`ifdef IFETCH_ACCESS_ERR_EN
        logic        err;
`endif
    } resp_t;

    logic [31:0]      mem_q [MEM_WORDS];

    logic [PIPE_N-1:0] pv_q, pv_d;
    resp_t            pd_q [PIPE_N];

    resp_t            fifo_q [DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0]      off_c;
    logic [63:0]      woff_c;
    logic [IDX_W-1:0] ridx_c;
    logic [IDX_W-1:0] widx_c;
    resp_t            in_c;
    resp_t            push_data_c;
    resp_t            head_c;
    logic             accept_c;
    logic             pop_c;
    logic             push_c;
    logic             empty_c;
    logic             unused_c;

    assign off_c  = addr_i - BASE_ADDR;
    assign woff_c = load_addr_i - BASE_ADDR;
    assign ridx_c = off_c[IDX_W+1:2];
    assign widx_c = woff_c[IDX_W+1:2];
    assign unused_c = ^{off_c[63:IDX_W+2], off_c[1:0], woff_c[63:IDX_W+2], woff_c[1:0]};

    // Request payload; RAM read is combinational so a same-edge backdoor write is not seen
    always_comb begin
        in_c      = '0;
        in_c.addr = addr_i;
`ifdef IFETCH_ACCESS_ERR_EN
        in_c.err  = (addr_i[1:0] != 2'b00) || (off_c >= (64'(4) * 64'(MEM_WORDS)));
        in_c.data = in_c.err ? 32'h0 : mem_q[ridx_c];
`else
        in_c.data = mem_q[ridx_c];
`endif
    end

    assign empty_c       = (wptr_q == rptr_q);
    assign addr_ok_o     = ~rst & ~flush_i & (cnt_q < CNT_W'(DEPTH));
    assign accept_c      = read_req_i & addr_ok_o;
    assign rdata_valid_o = ~empty_c & ~flush_i;
    assign pop_c         = rdata_valid_o & rdata_ready_i;

    // The FIFO write acts as the final latency stage
    assign push_c      = (LATENCY == 1) ? accept_c : pv_q[PIPE_N-1];
    assign push_data_c = (LATENCY == 1) ? in_c : pd_q[PIPE_N-1];

    assign head_c       = fifo_q[rptr_q[PTR_W-1:0]];
    assign rdata_o      = empty_c ? 32'h0 : head_c.data;
    assign rdata_addr_o = empty_c ? 64'h0 : head_c.addr;
`ifdef IFETCH_ACCESS_ERR_EN
    assign err_o        = rdata_valid_o & head_c.err;
`endif

    always_comb begin
        pv_d    = '0;
        pv_d[0] = accept_c;
        for (int i = 1; i < int'(PIPE_N); i++) begin
            pv_d[i] = pv_q[i-1];
        end
        if (flush_i) begin
            pv_d = '0;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_c) begin
                wptr_d = wptr_q + (PTR_W+1)'(1);
            end
            if (pop_c) begin
                rptr_d = rptr_q + (PTR_W+1)'(1);
            end
            case ({accept_c, pop_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            pv_q   <= pv_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity lives in pv_q and the FIFO pointers
    always_ff @(posedge clk) begin
        pd_q[0] <= in_c;
        for (int i = 1; i < int'(PIPE_N); i++) begin
            pd_q[i] <= pd_q[i-1];
        end
        if (push_c) begin
            fifo_q[wptr_q[PTR_W-1:0]] <= push_data_c;
        end
        if (load_wen_i) begin
            mem_q[widx_c] <= load_data_i;
        end
    end

endmodule
